// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding, data width
// and the baud-timer sizing function.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} rx_state_t;

  localparam int DATA_BITS = 8;

  typedef struct packed {
    int width;  // timer counter width
    int tc;     // terminal count, BIT-1
  } bit_cfg_t;

  // Cycles per bit is an integer divide; the timer must hold values up to BIT-1.
  function automatic bit_cfg_t bit_cycles(input int clk_hz, input int baud);
    bit_cfg_t cfg;
    int       bits;
    bits      = clk_hz / baud;
    cfg.tc    = bits - 1;
    cfg.width = (bits > 2) ? $clog2(bits) : 1;
    return cfg;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART receiver: counts 0..BIT-1 and flags the
// half-bit and full-bit terminal counts.
module uart_bit_timer #(
  parameter int BIT = 10,
  parameter int W   = $clog2(BIT)
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  output logic half_tc,
  output logic full_tc
);

  localparam int HALF = BIT / 2;

  logic [W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset || clr || full_tc) count <= '0;
    else                         count <= count + W'(1);
  end

  assign half_tc = (count == W'(HALF - 1));
  assign full_tc = (count == W'(BIT - 1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled at mid-bit, held on Dout until acknowledged.
// Define UART_RX_PARITY_EN to expect an odd-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sin,
  input  logic       ReceiveAck,
  output logic [7:0] Dout,
  output logic       Received,
  output logic       parityErr,
  output logic       frameErr,
  output logic       overrun
);

  localparam bit_cfg_t BC  = bit_cycles(CLK_FREQUENCY, BAUD_RATE);
  localparam int       BIT = BC.tc + 1;
  localparam int       TW  = BC.width;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ss, ss_d;
  rx_state_t              state, state_nx;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   half_tc, full_tc;
  logic                   timer_clr, shift_en, stop_en, commit;

  // Sync flops reset to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sync_q <= '1;
      ss_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Sin};
      ss_d   <= ss;
    end
  end

  assign ss = sync_q[SYNC_STAGES-1];

  uart_bit_timer #(.BIT(BIT), .W(TW)) u_timer (
    .clk     (clk),
    .Reset   (Reset),
    .clr     (timer_clr),
    .half_tc (half_tc),
    .full_tc (full_tc)
  );

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (ss_d && !ss) state_nx = START;
      START: if (half_tc) state_nx = ss ? IDLE : DATA;
      DATA:
        if (full_tc && bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_nx = PAR;
`else
          state_nx = STOP;
`endif
        end
      PAR:     if (full_tc) state_nx = STOP;
      STOP:    if (full_tc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    timer_clr = 1'b0;
    shift_en  = 1'b0;
    stop_en   = 1'b0;
    case (state)
      IDLE:    timer_clr = 1'b1;
      START:   timer_clr = half_tc;
      DATA:    shift_en  = full_tc;
      STOP:    stop_en   = full_tc;
      default: timer_clr = (state != PAR);
    endcase
  end

  assign commit = stop_en && ss;

  always_ff @(posedge clk) begin
    if (Reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (timer_clr)     bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {ss, shreg[7:1]};
    end
  end

  // A commit takes priority over a same-cycle ack: the new byte is still pending.
  always_ff @(posedge clk) begin
    if (Reset) begin
      Dout     <= '0;
      Received <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else if (commit) begin
      Dout     <= shreg;
      Received <= 1'b1;
      frameErr <= 1'b0;
      overrun  <= Received && !ReceiveAck;
    end else begin
      if (stop_en) frameErr <= 1'b1;
      if (ReceiveAck && Received) begin
        Received <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (Reset) begin
      par_bit   <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      if (state == PAR && full_tc) par_bit <= ss;
      if (commit) parityErr <= ~(^{shreg, par_bit});
    end
  end
`else
  assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames checked
// against a frame-level model of the receiver's output flags.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FRAME_CYC = BIT * (10 + PAR_EN);
  // Drive iteration whose ack lands on the stop-bit sampling edge.
  localparam int COMMIT_IT = 2 + BIT / 2 + (9 + PAR_EN) * BIT;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Sin = 1'b1;
  logic       ReceiveAck = 1'b0;
  logic [7:0] Dout;
  logic       Received, parityErr, frameErr, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_dout;
  logic       m_recv, m_perr, m_ferr, m_ovr;

  uart_rx #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Sin        (Sin),
    .ReceiveAck (ReceiveAck),
    .Dout       (Dout),
    .Received   (Received),
    .parityErr  (parityErr),
    .frameErr   (frameErr),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Dout"},      32'(Dout),      32'(m_dout));
    check({tag, ".Received"},  32'(Received),  32'(m_recv));
    check({tag, ".parityErr"}, 32'(parityErr), 32'(m_perr));
    check({tag, ".frameErr"},  32'(frameErr),  32'(m_ferr));
    check({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
  endtask

  task automatic model_reset();
    m_dout = '0;
    m_recv = 1'b0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // What one complete frame does to the outputs, from the protocol rules alone.
  task automatic model_frame(input logic [7:0] data, input logic par_bit,
                             input logic stop_bit, input logic ack_coincide);
    if (stop_bit) begin
      m_ovr  = m_recv && !ack_coincide;
      m_dout = data;
      m_recv = 1'b1;
      m_ferr = 1'b0;
      m_perr = (PAR_EN == 1) ? ((($countones(data) + int'(par_bit)) % 2) == 0) : 1'b0;
    end else begin
      m_ferr = 1'b1;
      if (ack_coincide) begin
        m_recv = 1'b0;
        m_ovr  = 1'b0;
      end
    end
  endtask

  function automatic logic odd_par(input logic [7:0] data);
    return ~(^data);
  endfunction

  // Drives one frame; ack_at / abort_at name a drive iteration (-1 = never).
  task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                            input int ack_at, input int abort_at);
    for (int i = 0; i < FRAME_CYC; i++) begin
      int   b;
      logic v;
      if (i == abort_at) begin
        Reset      = 1'b1;
        Sin        = 1'b1;
        ReceiveAck = 1'b0;
        tick(2);
        Reset = 1'b0;
        return;
      end
      b = i / BIT;
      if (b == 0)                     v = 1'b0;
      else if (b <= 8)                v = data[b-1];
      else if (b == 9 && PAR_EN == 1) v = par_bit;
      else                            v = stop_bit;
      Sin        = v;
      ReceiveAck = (i == ack_at);
      tick(1);
    end
    Sin        = 1'b1;
    ReceiveAck = 1'b0;
    tick(15);
  endtask

  task automatic frame(input string tag, input logic [7:0] data, input logic par_bit,
                       input logic stop_bit, input logic ack_coincide);
    send_frame(data, par_bit, stop_bit, ack_coincide ? COMMIT_IT : -1, -1);
    model_frame(data, par_bit, stop_bit, ack_coincide);
    check_all(tag);
  endtask

  task automatic ack_pulse(input string tag);
    ReceiveAck = 1'b1;
    tick(1);
    ReceiveAck = 1'b0;
    if (m_recv) begin
      m_recv = 1'b0;
      m_ovr  = 1'b0;
    end
    check_all(tag);
    tick(1);
  endtask

  initial begin
    logic seen;
    model_reset();

    Reset = 1'b1;
    Sin   = 1'b1;
    tick(3);
    Reset = 1'b0;
    check_all("reset");
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (Received) seen = 1'b1;
    end
    check("idle_quiet", 32'(seen), 32'd0);

    frame("a5", 8'hA5, odd_par(8'hA5), 1'b1, 1'b0);
    ack_pulse("a5_ack");

    Sin = 1'b0;
    tick(3);
    Sin = 1'b1;
    tick(30);
    check_all("glitch");

    frame("bad_stop_3c", 8'h3C, odd_par(8'h3C), 1'b0, 1'b0);
    frame("good_01", 8'h01, odd_par(8'h01), 1'b1, 1'b0);
    ack_pulse("01_ack");

    frame("ovr_11", 8'h11, odd_par(8'h11), 1'b1, 1'b0);
    frame("ovr_22", 8'h22, odd_par(8'h22), 1'b1, 1'b0);
    ack_pulse("ovr_ack");
    frame("ovr_33", 8'h33, odd_par(8'h33), 1'b1, 1'b0);
    frame("ovr_44", 8'h44, odd_par(8'h44), 1'b1, 1'b0);
    frame("ack_with_commit_55", 8'h55, odd_par(8'h55), 1'b1, 1'b1);
    ack_pulse("55_ack");

`ifdef UART_RX_PARITY_EN
    frame("par_err_0f", 8'h0F, 1'b0, 1'b1, 1'b0);
    ack_pulse("0f_ack");
`endif

    frame("pre_abort_c3", 8'hC3, odd_par(8'hC3), 1'b1, 1'b0);
    send_frame(8'h96, odd_par(8'h96), 1'b1, -1, 5 * BIT + BIT / 2);
    model_reset();
    tick(30);
    check_all("reset_mid_frame");
    frame("after_abort_5a", 8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
    ack_pulse("5a_ack");

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       stop, par, coincide;
      int         mode;
      d        = 8'($urandom);
      stop     = ($urandom_range(0, 4) != 0);
      par      = odd_par(d) ^ ($urandom_range(0, 3) == 0);
      mode     = int'($urandom_range(0, 3));
      coincide = (mode == 0);
      frame($sformatf("rand%0d", n), d, par, stop, coincide);
      if (mode == 1) ack_pulse($sformatf("rand%0d_ack", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
